player_motion_ctrl: RTL
=======================

# player_motion_ctrl

Parametrised successor to the dino player controller. It merges the game-state FSM and jump physics into one block. It adds configurable jump velocity and gravity, fast-fall, a multi-life counter with a post-hit invulnerability window, and registered single-cycle event pulses. It sits between the button inputs / collision detector and the renderer and score logic, and is clocked by the system clock with frame and physics strobes on `game_tick`.

## Interface
- `POS_W`, 6: width of `player_position` (unsigned height above ground).
- `JUMP_V0`, 8: initial upward velocity loaded at jump start; must be < 2^POS_W.
- `GRAVITY`, 1: velocity decrement per physics tick; fast-fall uses 2*GRAVITY.
- `LIVES`, 3: lives at game start, 1..15.
- `INVULN_TICKS`, 4: number of frame ticks of crash immunity after a non-fatal hit, ≥1.

- `clk` in 1: system clock.
- `reset_n` in 1: synchronous, active-low reset.
- `game_tick` in 2: bit0 is the frame strobe (input sampling, FSM), bit1 is the physics strobe; each strobe is one cycle wide, and the two may coincide.
- `button_up` in 1: jump / start request (level).
- `button_down` in 1: duck / fast-fall request (level).
- `crash` in 1: collision indication (level).
- `player_position` out POS_W: current height, 0 = ground.
- `jumping` out 1: state is JUMPING.
- `ducking` out 1: state is DUCKING.
- `invulnerable` out 1: invulnerability counter is non-zero.
- `lives_left` out 4: remaining lives.
- `game_start_pulse`, `jump_pulse`, `hit_pulse`, `game_over_pulse` out 1 each: single-cycle event strobes.

## Operation
- States: RESTART, RUNNING, JUMPING, DUCKING, GAME_OVER. Transitions are evaluated only on cycles with `game_tick[0]`=1, except landing (see below).
- **RESTART:** `button_up` → JUMPING. Assert `game_start_pulse` and `jump_pulse`, load vel=JUMP_V0.
- **RUNNING:** priority order:
  - crash: handled by the hit rule.
  - `button_down` → DUCKING.
  - `button_up` → JUMPING, with `jump_pulse` and vel=JUMP_V0.
- **DUCKING:** crash is handled first by the hit rule. Then `!button_down` → RUNNING.
- **JUMPING:** crash is handled by the hit rule. Exit happens only by landing.
- **GAME_OVER:** `button_up` → RUNNING. lives_left=LIVES, invulnerability cleared, position=0, assert `game_start_pulse`.
- **Hit rule** (RUNNING/JUMPING/DUCKING, tick0, crash=1, invulnerable=0):
  - If lives_left==1: lives_left=0, → GAME_OVER, assert `game_over_pulse` and `hit_pulse`.
  - Otherwise: lives_left−1, counter=INVULN_TICKS, assert `hit_pulse`, and the state is unchanged.
  - Crash while invulnerable is ignored and does not block lower-priority transitions.
- **Invulnerability counter:** decrements by 1 on each tick0 while non-zero, except on the tick that loads it.
- **Physics** (tick1, state JUMPING, not the cycle that loaded vel):
  - Compute next = pos + vel as signed, POS_W+2 bits wide.
  - If next ≤ 0 and vel < 0: pos=0, vel=0, → DUCKING if `button_down` else RUNNING (landing).
  - Else if next > 2^POS_W−1: pos saturates to max.
  - Else pos = next.
  - Then vel −= (`button_down` ? 2*GRAVITY : GRAVITY).
  - vel is signed, POS_W+2 bits; it must not overflow for legal parameters.
- Position is frozen in GAME_OVER and is 0 in all other non-JUMPING states.

## Timing
- **Reset:** state RESTART, pos 0, vel 0, lives_left=LIVES, invulnerable 0, `jumping`/`ducking` 0, all pulses 0.
- **Registered outputs:** all outputs are registered. State and flag outputs update on the clock edge ending the tick cycle, so they are visible the next cycle.
- **Pulses:** high for exactly one cycle, the cycle after the tick that caused them. They are never high on consecutive cycles from one event.
- **Coinciding strobes:** when tick0 and tick1 coincide, the FSM decision uses the pre-edge state.
  - The physics step applies only if the pre-edge state is JUMPING and no jump load occurs.
  - If crash→GAME_OVER and landing occur in the same cycle, GAME_OVER wins and pos keeps the physics result.
  - A non-fatal hit plus landing: both take effect.
- **Mid-operation reset:** reset takes effect on the next edge regardless of ticks and aborts jump, invulnerability and pulses.
- **Latency:** button press → `jumping` = 1 cycle after the tick0. First position change occurs at the next tick1.

## Test plan
- **Reset then start:** reset, tick0 with button_up → next cycle `game_start_pulse`=`jump_pulse`=1 for one cycle, `jumping`=1, lives_left=3.
- **Full jump trajectory (defaults, no buttons):** successive tick1s give pos 8,15,21,26,30,33,35,36,36,35,33,30,26,21,15,8,0. `jumping` drops after the 17th tick1.
- **Fast-fall:** hold button_down from apex (pos 36) → descent uses decrement 2, landing occurs in fewer tick1s, and state ends in DUCKING.
- **Non-fatal hit:** crash on a tick0 in RUNNING → `hit_pulse`, lives 2, invulnerable=1 for 4 tick0s. A crash during that window → no pulse, lives unchanged.
- **Fatal sequence:** three separated hits → lives 0, `game_over_pulse` and `hit_pulse` on the same cycle, GAME_OVER, pos frozen. button_up on tick0 → RUNNING, lives 3, `game_start_pulse`.
- **Simultaneous events:** tick0+tick1 with crash and button_up in RUNNING → hit taken, no jump_pulse. Reset asserted mid-jump → next cycle pos 0, RESTART, all outputs at reset values.

Source files
------------

// File: rtl/player_motion_ctrl_if.sv
// Signal bundle between the player controller and its environment
// (buttons / collision detector on one side, renderer / score on the other).
interface player_motion_ctrl_if #(
    parameter int POS_W = 6
);
    logic [1:0]       game_tick;
    logic             button_up;
    logic             button_down;
    logic             crash;
    logic [POS_W-1:0] player_position;
    logic             jumping;
    logic             ducking;
    logic             invulnerable;
    logic [3:0]       lives_left;
    logic             game_start_pulse;
    logic             jump_pulse;
    logic             hit_pulse;
    logic             game_over_pulse;

    modport master (
        output game_tick, button_up, button_down, crash,
        input  player_position, jumping, ducking, invulnerable, lives_left,
        input  game_start_pulse, jump_pulse, hit_pulse, game_over_pulse
    );

    modport slave (
        input  game_tick, button_up, button_down, crash,
        output player_position, jumping, ducking, invulnerable, lives_left,
        output game_start_pulse, jump_pulse, hit_pulse, game_over_pulse
    );
endinterface

// File: rtl/player_motion_ctrl.sv
// Player game-state FSM with jump physics, lives, post-hit invulnerability
// and registered one-cycle event pulses. Frame strobe = tick[0], physics = tick[1].
module player_motion_ctrl #(
    parameter int POS_W        = 6,
    parameter int JUMP_V0      = 8,
    parameter int GRAVITY      = 1,
    parameter int LIVES        = 3,
    parameter int INVULN_TICKS = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    player_motion_ctrl_if.slave   bus
);
    localparam int VW    = POS_W + 2;
    localparam int CNT_W = $clog2(INVULN_TICKS + 1);

    localparam logic signed [VW-1:0] ZERO_S    = '0;
    localparam logic signed [VW-1:0] V0_S      = VW'(JUMP_V0);
    localparam logic signed [VW-1:0] GRAV_S    = VW'(GRAVITY);
    localparam logic signed [VW-1:0] GRAV2_S   = VW'(2 * GRAVITY);
    localparam logic signed [VW-1:0] POS_MAX_S = VW'((2 ** POS_W) - 1);
    localparam logic [POS_W-1:0]     POS_MAX   = '1;
    localparam logic [3:0]           LIVES_INIT = 4'(LIVES);
    localparam logic [CNT_W-1:0]     INVULN_INIT = CNT_W'(INVULN_TICKS);

    typedef enum logic [2:0] {
        ST_RESTART,
        ST_RUNNING,
        ST_JUMPING,
        ST_DUCKING,
        ST_GAME_OVER
    } state_t;

    state_t                 state_q, state_d;
    logic [POS_W-1:0]       pos_q, pos_d;
    logic signed [VW-1:0]   vel_q, vel_d;
    logic [3:0]             lives_q, lives_d;
    logic [CNT_W-1:0]       invuln_q, invuln_d;
    logic                   jumping_q, ducking_q, invulnerable_q;
    logic                   start_pulse_q, start_pulse_d;
    logic                   jump_pulse_q, jump_pulse_d;
    logic                   hit_pulse_q, hit_pulse_d;
    logic                   over_pulse_q, over_pulse_d;

    logic                   tick0, tick1;
    logic                   hit_ok, landed;
    logic signed [VW-1:0]   next_pos;

    assign tick0    = bus.game_tick[0];
    assign tick1    = bus.game_tick[1];
    assign next_pos = $signed({2'b00, pos_q}) + vel_q;

    always_comb begin
        state_d       = state_q;
        pos_d         = pos_q;
        vel_d         = vel_q;
        lives_d       = lives_q;
        invuln_d      = invuln_q;
        start_pulse_d = 1'b0;
        jump_pulse_d  = 1'b0;
        hit_pulse_d   = 1'b0;
        over_pulse_d  = 1'b0;
        landed        = 1'b0;

        hit_ok = tick0 && bus.crash && (invuln_q == '0) &&
                 ((state_q == ST_RUNNING) || (state_q == ST_JUMPING) ||
                  (state_q == ST_DUCKING));

        if (tick0 && (invuln_q != '0)) begin
            invuln_d = invuln_q - CNT_W'(1);
        end

        // Jump loads only happen outside JUMPING, so physics never sees a fresh load.
        if (tick1 && (state_q == ST_JUMPING)) begin
            if ((next_pos <= ZERO_S) && (vel_q < ZERO_S)) begin
                pos_d  = '0;
                vel_d  = ZERO_S;
                landed = 1'b1;
            end else begin
                if (next_pos > POS_MAX_S) begin
                    pos_d = POS_MAX;
                end else begin
                    pos_d = next_pos[POS_W-1:0];
                end
                vel_d = vel_q - (bus.button_down ? GRAV2_S : GRAV_S);
            end
        end

        case (state_q)
            ST_RESTART: begin
                if (tick0 && bus.button_up) begin
                    state_d       = ST_JUMPING;
                    vel_d         = V0_S;
                    start_pulse_d = 1'b1;
                    jump_pulse_d  = 1'b1;
                end
            end
            ST_RUNNING: begin
                if (tick0 && !hit_ok) begin
                    if (bus.button_down) begin
                        state_d = ST_DUCKING;
                    end else if (bus.button_up) begin
                        state_d      = ST_JUMPING;
                        vel_d        = V0_S;
                        jump_pulse_d = 1'b1;
                    end
                end
            end
            ST_JUMPING: begin
                if (landed) begin
                    state_d = bus.button_down ? ST_DUCKING : ST_RUNNING;
                end
            end
            ST_DUCKING: begin
                if (tick0 && !hit_ok && !bus.button_down) begin
                    state_d = ST_RUNNING;
                end
            end
            ST_GAME_OVER: begin
                if (tick0 && bus.button_up) begin
                    state_d       = ST_RUNNING;
                    lives_d       = LIVES_INIT;
                    invuln_d      = '0;
                    pos_d         = '0;
                    vel_d         = ZERO_S;
                    start_pulse_d = 1'b1;
                end
            end
            default: state_d = ST_RESTART;
        endcase

        // A fatal hit overrides landing but keeps whatever position physics produced.
        if (hit_ok) begin
            hit_pulse_d = 1'b1;
            if (lives_q == 4'd1) begin
                lives_d      = 4'd0;
                state_d      = ST_GAME_OVER;
                over_pulse_d = 1'b1;
            end else begin
                lives_d  = lives_q - 4'd1;
                invuln_d = INVULN_INIT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= ST_RESTART;
            pos_q          <= '0;
            vel_q          <= ZERO_S;
            lives_q        <= LIVES_INIT;
            invuln_q       <= '0;
            jumping_q      <= 1'b0;
            ducking_q      <= 1'b0;
            invulnerable_q <= 1'b0;
            start_pulse_q  <= 1'b0;
            jump_pulse_q   <= 1'b0;
            hit_pulse_q    <= 1'b0;
            over_pulse_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            pos_q          <= pos_d;
            vel_q          <= vel_d;
            lives_q        <= lives_d;
            invuln_q       <= invuln_d;
            jumping_q      <= (state_d == ST_JUMPING);
            ducking_q      <= (state_d == ST_DUCKING);
            invulnerable_q <= (invuln_d != '0);
            start_pulse_q  <= start_pulse_d;
            jump_pulse_q   <= jump_pulse_d;
            hit_pulse_q    <= hit_pulse_d;
            over_pulse_q   <= over_pulse_d;
        end
    end

    assign bus.player_position  = pos_q;
    assign bus.jumping          = jumping_q;
    assign bus.ducking          = ducking_q;
    assign bus.invulnerable     = invulnerable_q;
    assign bus.lives_left       = lives_q;
    assign bus.game_start_pulse = start_pulse_q;
    assign bus.jump_pulse       = jump_pulse_q;
    assign bus.hit_pulse        = hit_pulse_q;
    assign bus.game_over_pulse  = over_pulse_q;

endmodule
